// File: rtl/hdmi_pixel_framer.sv
// Frames decoded HDMI timing (DE/HSYNC/VSYNC/RGB) into per-pixel strobes plus measured geometry and lock.
// Optional feature macro: HDMI_PIXEL_FRAMER_AUTOPOL_EN (learn VSYNC polarity from active video).
module hdmi_pixel_framer #(
  parameter int XBITS = 13,
  parameter int YBITS = 11
) (
  input  logic             i_pix_clk,
  input  logic             i_reset_n,
  input  logic             i_de,
  input  logic             i_hsync,
  input  logic             i_vsync,
  input  logic [7:0]       i_r,
  input  logic [7:0]       i_g,
  input  logic [7:0]       i_b,
  output logic             o_pix_valid,
  output logic             o_pix_newline,
  output logic             o_pix_eol,
  output logic             o_pix_eof,
  output logic [7:0]       o_pix_r,
  output logic [7:0]       o_pix_g,
  output logic [7:0]       o_pix_b,
  output logic             o_pix_hsync,
  output logic [XBITS-1:0] o_pix_npix,
  output logic [YBITS-1:0] o_pix_nlines,
  output logic             o_locked
);

  logic             last_de;
  logic             last_vs;
  logic             vs_pol;
  logic             seen_idle;
  logic             have_line;
  logic             mismatch;
  logic             prev_clean;
  logic [XBITS-1:0] xcnt;
  logic [XBITS-1:0] line_len;
  logic [YBITS-1:0] ycnt;

  logic             vs_active;
  logic             de_rise;
  logic             de_fall;
  logic             vs_rise;
  logic [XBITS-1:0] line_len_nxt;
  logic [YBITS-1:0] ycnt_nxt;
  logic             mismatch_nxt;
  logic             frame_clean;

`ifdef HDMI_PIXEL_FRAMER_AUTOPOL_EN
  // Sync is inactive during active video, so its level there is the inactive polarity.
  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vs_pol <= 1'b1;
    end else if (i_de) begin
      vs_pol <= ~i_vsync;
    end
  end
`else
  assign vs_pol = 1'b1;
`endif

  // Next-state of the line bookkeeping, so an eof coinciding with an eol sees the finished line.
  always_comb begin
    vs_active    = ~(i_vsync ^ vs_pol);
    de_rise      = i_de & ~last_de;
    de_fall      = ~i_de & last_de;
    vs_rise      = vs_active & ~last_vs;
    line_len_nxt = line_len;
    ycnt_nxt     = ycnt;
    mismatch_nxt = mismatch;
    if (de_fall) begin
      line_len_nxt = xcnt;
      if (ycnt != '1) ycnt_nxt = ycnt + YBITS'(1);
      if (have_line && (xcnt != line_len)) mismatch_nxt = 1'b1;
    end
    frame_clean = ~mismatch_nxt & (ycnt_nxt != '0);
  end

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_de       <= 1'b0;
      last_vs       <= 1'b0;
      seen_idle     <= 1'b0;
      have_line     <= 1'b0;
      mismatch      <= 1'b0;
      prev_clean    <= 1'b0;
      xcnt          <= '0;
      line_len      <= '0;
      ycnt          <= '0;
      o_pix_valid   <= 1'b0;
      o_pix_newline <= 1'b0;
      o_pix_eol     <= 1'b0;
      o_pix_eof     <= 1'b0;
      o_pix_r       <= '0;
      o_pix_g       <= '0;
      o_pix_b       <= '0;
      o_pix_hsync   <= 1'b0;
      o_pix_npix    <= '0;
      o_pix_nlines  <= '0;
      o_locked      <= 1'b0;
    end else begin
      last_de       <= i_de;
      last_vs       <= vs_active;
      if (!i_de) seen_idle <= 1'b1;
      o_pix_valid   <= i_de;
      o_pix_r       <= i_de ? i_r : 8'd0;
      o_pix_g       <= i_de ? i_g : 8'd0;
      o_pix_b       <= i_de ? i_b : 8'd0;
      // A line already running when reset released has no observed start, so no newline.
      o_pix_newline <= de_rise & seen_idle;
      o_pix_eol     <= de_fall;
      o_pix_eof     <= vs_rise;
      o_pix_hsync   <= i_hsync;

      if (de_rise) xcnt <= XBITS'(1);
      else if (i_de && (xcnt != '1)) xcnt <= xcnt + XBITS'(1);

      line_len <= line_len_nxt;
      if (vs_rise) begin
        o_pix_npix   <= line_len_nxt;
        o_pix_nlines <= ycnt_nxt;
        // The previous frame must also have been clean for the geometry to count as stable.
        o_locked     <= frame_clean & prev_clean &
                        (line_len_nxt == o_pix_npix) & (ycnt_nxt == o_pix_nlines);
        prev_clean   <= frame_clean;
        ycnt         <= '0;
        mismatch     <= 1'b0;
        have_line    <= 1'b0;
      end else begin
        ycnt     <= ycnt_nxt;
        mismatch <= mismatch_nxt;
        if (de_fall) have_line <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_pixel_framer.sv
// Scoreboard bench for hdmi_pixel_framer: the driver queues expected pixels/eols/geometry, a monitor checks them.
// Honours HDMI_PIXEL_FRAMER_AUTOPOL_EN for the expected eof position of active-low VSYNC.
module tb_hdmi_pixel_framer;
  localparam int XB = 13;
  localparam int YB = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_de = 1'b0, i_hsync = 1'b0, i_vsync = 1'b0;
  logic [7:0]    i_r = '0, i_g = '0, i_b = '0;
  logic          o_pix_valid, o_pix_newline, o_pix_eol, o_pix_eof, o_pix_hsync, o_locked;
  logic [7:0]    o_pix_r, o_pix_g, o_pix_b;
  logic [XB-1:0] o_pix_npix;
  logic [YB-1:0] o_pix_nlines;

  // Handshake: the DUT presents a pixel when o_pix_valid=1 and an eol/eof pulse for one cycle; no back-pressure.
  logic [24:0]      pix_q[$];   // {newline, rgb}
  logic [0:0]       eol_q[$];
  logic [XB+YB+1:0] geom_q[$];  // {vsync level at eof, npix, nlines, locked}

  int   n_vec = 0;
  int   n_err = 0;
  logic drv_prev_de = 1'b0;
  logic drv_idle = 1'b0;
  logic vs_idle = 1'b0;

  hdmi_pixel_framer #(.XBITS(XB), .YBITS(YB)) dut (
    .i_pix_clk(clk), .i_reset_n(rst_n), .i_de(i_de), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_pix_valid(o_pix_valid), .o_pix_newline(o_pix_newline), .o_pix_eol(o_pix_eol),
    .o_pix_eof(o_pix_eof), .o_pix_r(o_pix_r), .o_pix_g(o_pix_g), .o_pix_b(o_pix_b),
    .o_pix_hsync(o_pix_hsync), .o_pix_npix(o_pix_npix), .o_pix_nlines(o_pix_nlines),
    .o_locked(o_locked)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic de, input logic hs, input logic vs, input logic [23:0] rgb);
    @(negedge clk);
    i_de = de;
    i_hsync = hs;
    i_vsync = vs;
    {i_r, i_g, i_b} = de ? rgb : 24'($urandom);
    if (rst_n) begin
      if (de) pix_q.push_back({~drv_prev_de & drv_idle, rgb});
      if (!de && drv_prev_de) eol_q.push_back(1'b1);
      drv_prev_de = de;
      if (!de) drv_idle = 1'b1;
    end
  endtask

  task automatic blank();
    for (int i = 0; i < 4; i++) step(1'b0, (i == 1) || (i == 2), vs_idle, 24'h0);
  endtask

  task automatic drive_line(input int np, input int base);
    for (int i = 0; i < np; i++) step(1'b1, 1'b0, vs_idle, 24'(base + i));
    blank();
  endtask

  task automatic drive_sync(input int np, input int nl, input logic lk, input logic lvl);
    geom_q.push_back({lvl, XB'(np), YB'(nl), lk});
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, ~vs_idle, 24'h0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, vs_idle, 24'h0);
  endtask

  task automatic frame(input int nl, input int np, input int bad_idx, input int bad_np,
                       input int e_np, input int e_nl, input logic e_lk, input logic e_lvl);
    for (int l = 0; l < nl; l++) drive_line((l == bad_idx) ? bad_np : np, 24'h102030 + l * 24'h010101);
    drive_sync(e_np, e_nl, e_lk, e_lvl);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, o_pix_valid, 0);
    chk({tag, "_newline"}, o_pix_newline, 0);
    chk({tag, "_eol"}, o_pix_eol, 0);
    chk({tag, "_eof"}, o_pix_eof, 0);
    chk({tag, "_rgb"}, {o_pix_r, o_pix_g, o_pix_b}, 0);
    chk({tag, "_hsync"}, o_pix_hsync, 0);
    chk({tag, "_npix"}, o_pix_npix, 0);
    chk({tag, "_nlines"}, o_pix_nlines, 0);
    chk({tag, "_locked"}, o_locked, 0);
  endtask

  task automatic assert_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    pix_q.delete();
    eol_q.delete();
    geom_q.delete();
    drv_prev_de = 1'b0;
    drv_idle = 1'b0;
    #1;
    check_reset_outputs(tag);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic             mon_prev_valid = 1'b0;
  logic             geom_pend = 1'b0;
  logic [XB+YB:0]   geom_held = '0;
  logic [XB+YB:0]   geom_exp = '0;
  logic [XB+YB:0]   geom_cur;
  logic [24:0]      pix_exp;
  logic [XB+YB+1:0] g_ent;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mon_prev_valid = 1'b0;
        geom_pend = 1'b0;
        geom_held = '0;
      end else begin
        chk("hsync_delay", o_pix_hsync, i_hsync);
        if (o_pix_valid) begin
          chk("pix_expected", pix_q.size() != 0, 1);
          if (pix_q.size() != 0) begin
            pix_exp = pix_q.pop_front();
            chk("pix_newline_rgb", {o_pix_newline, o_pix_r, o_pix_g, o_pix_b}, pix_exp);
          end
        end else begin
          chk("idle_newline_rgb", {o_pix_newline, o_pix_r, o_pix_g, o_pix_b}, 0);
        end
        if (o_pix_eol) begin
          chk("eol_expected", eol_q.size() != 0, 1);
          if (eol_q.size() != 0) void'(eol_q.pop_front());
          chk("eol_not_valid", o_pix_valid, 0);
        end
        if (mon_prev_valid && !o_pix_valid) chk("eol_after_line", o_pix_eol, 1);
        geom_cur = {o_pix_npix, o_pix_nlines, o_locked};
        if (geom_pend) begin
          chk("geometry_at_eof", geom_cur, geom_exp);
          geom_pend = 1'b0;
        end else if (!o_pix_eof) begin
          chk("geometry_stable", geom_cur, geom_held);
        end
        geom_held = geom_cur;
        if (o_pix_eof) begin
          chk("eof_expected", geom_q.size() != 0, 1);
          if (geom_q.size() != 0) begin
            g_ent = geom_q.pop_front();
            chk("eof_vsync_level", i_vsync, g_ent[XB+YB+1]);
            geom_exp = g_ent[XB+YB:0];
            geom_pend = 1'b1;
          end
        end
        mon_prev_valid = o_pix_valid;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic low_lvl;
`ifdef HDMI_PIXEL_FRAMER_AUTOPOL_EN
    low_lvl = 1'b0;
`else
    low_lvl = 1'b1;
`endif
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    release_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 24'h0);

    // 16x6 frames; lock after the second clean frame
    frame(6, 16, -1, 0, 16, 6, 1'b0, 1'b1);
    frame(6, 16, -1, 0, 16, 6, 1'b1, 1'b1);
    // line 2 one pixel short: lock drops, stays down one clean frame, then returns
    frame(6, 16, 2, 15, 16, 6, 1'b0, 1'b1);
    frame(6, 16, -1, 0, 16, 6, 1'b0, 1'b1);
    frame(6, 16, -1, 0, 16, 6, 1'b1, 1'b1);

    // single-pixel line with known colour
    drive_line(1, 24'h123456);
    drive_sync(1, 1, 1'b0, 1'b1);

    // 9000-pixel line saturates the 13-bit counter
    drive_line(9000, 24'hA00000);
    drive_sync(8191, 1, 1'b0, 1'b1);

    // asynchronous reset in the middle of line 4
    for (int l = 0; l < 3; l++) drive_line(16, 24'h300000 + l * 16);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 24'h400000 + i);
    assert_reset("midreset");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 24'h400010 + i);
    release_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 24'h400020 + i);
    blank();
    drive_line(16, 24'h500000);
    drive_line(16, 24'h600000);
    drive_sync(16, 3, 1'b0, 1'b1);
    frame(6, 16, -1, 0, 16, 6, 1'b0, 1'b1);
    frame(6, 16, -1, 0, 16, 6, 1'b1, 1'b1);

    // active-low VSYNC, idle high from reset: reset release itself yields an empty eof
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 24'h0);
    assert_reset("polreset");
    vs_idle = 1'b1;
    geom_q.push_back({1'b1, XB'(0), YB'(0), 1'b0});
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 24'h0);
    release_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 24'h0);
    frame(6, 16, -1, 0, 16, 6, 1'b0, low_lvl);
    frame(6, 16, -1, 0, 16, 6, 1'b1, low_lvl);

    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, vs_idle, 24'h0);
    chk("pix_q_drained", pix_q.size(), 0);
    chk("eol_q_drained", eol_q.size(), 0);
    chk("geom_q_drained", geom_q.size(), 0);
    chk("geom_check_done", geom_pend, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
